// File: rtl/mem_access_unit.sv
// mem_access_unit: requester-side bus master for the 13-bit Main_Memory
// handshake. Takes one load/store/fetch request at a time, drives the memory
// strobes until Done, then returns a single-cycle response.
//
// Parameters:
//   TIMEOUT   WAIT cycles without mem_done before abort (1..255)
// Build option:
//   MEM_ACCESS_TIMEOUT_EN  when defined, a WAIT that reaches TIMEOUT cycles
//                          ends with rsp_error=1; otherwise WAIT lasts until
//                          mem_done and rsp_error is tied to 0.
// Ports:
//   clk, reset          clock, async active-high reset
//   req_valid/ready     request handshake (ready high only in IDLE)
//   req_write/instr     store select / instruction-space select
//   req_addr/wdata      13-bit word address / store data
//   rsp_valid/rdata/error  one-cycle response pulse with read data / timeout
//   mem_*               Main_Memory address, data, strobes and Done
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_instr,
    input  logic [12:0] req_addr,
    input  logic [12:0] req_wdata,
    output logic        rsp_valid,
    output logic [12:0] rsp_rdata,
    output logic        rsp_error,
    output logic [12:0] mem_address,
    output logic [12:0] mem_dataIn,
    input  logic [12:0] mem_dataOut,
    output logic        mem_write,
    output logic        mem_read,
    output logic        mem_instruction,
    input  logic        mem_done
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_access_unit: TIMEOUT must be in 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    logic        r_ready;
    logic        r_rsp_valid;
    logic [12:0] r_rsp_rdata;
    logic [12:0] r_addr;
    logic [12:0] r_wdata;
    logic        r_write;
    logic        r_read;
    logic        r_instr;

`ifdef MEM_ACCESS_TIMEOUT_EN
    // Counter value seen in WAIT on the edge that completes TIMEOUT cycles.
    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    logic [7:0]  r_cnt;
    logic        r_rsp_error;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_write     <= 1'b0;
            r_read      <= 1'b0;
            r_instr     <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            r_cnt       <= '0;
            r_rsp_error <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    // req_ready is always 1 here, so req_valid alone accepts.
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_instr <= req_instr;
                        r_write <= req_write;
                        r_read  <= ~req_write;
                        r_ready <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Done wins over a timeout landing on the same edge.
                    if (mem_done) begin
                        r_write     <= 1'b0;
                        r_read      <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_read ? mem_dataOut : 13'd0;
`ifdef MEM_ACCESS_TIMEOUT_EN
                        r_rsp_error <= 1'b0;
`endif
                        r_state     <= S_RESP;
                    end
`ifdef MEM_ACCESS_TIMEOUT_EN
                    else if (r_cnt == LP_LAST) begin
                        r_write     <= 1'b0;
                        r_read      <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_error <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
`endif
                end
                S_RESP: begin
                    r_rsp_valid <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
                    r_rsp_error <= 1'b0;
`endif
                    r_ready     <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready       = r_ready;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_rdata       = r_rsp_rdata;
    assign mem_address     = r_addr;
    assign mem_dataIn      = r_wdata;
    assign mem_write       = r_write;
    assign mem_read        = r_read;
    assign mem_instruction = r_instr;
`ifdef MEM_ACCESS_TIMEOUT_EN
    assign rsp_error       = r_rsp_error;
`else
    assign rsp_error       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed + randomized bench for mem_access_unit with a
// behavioural memory and reference store kept in the bench.
module tb_mem_access_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_instr;
    logic [12:0] req_addr;
    logic [12:0] req_wdata;
    logic        rsp_valid;
    logic [12:0] rsp_rdata;
    logic        rsp_error;
    logic [12:0] mem_address;
    logic [12:0] mem_dataIn;
    logic [12:0] mem_dataOut;
    logic        mem_write;
    logic        mem_read;
    logic        mem_instruction;
    logic        mem_done;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TMO)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_instr      (req_instr),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_error      (rsp_error),
        .mem_address    (mem_address),
        .mem_dataIn     (mem_dataIn),
        .mem_dataOut    (mem_dataOut),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_instruction(mem_instruction),
        .mem_done       (mem_done)
    );

    int checks   = 0;
    int failures = 0;

    // mem_arr: the memory as driven by the DUT's strobes.
    // ref_mem: what the requests alone say the memory should hold.
    bit [12:0] mem_arr [0:16383];
    bit [12:0] ref_mem [0:16383];

    task automatic check(input string tag, input logic [12:0] obs,
                         input logic [12:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the unit idle; returns at a negedge, idle.
    task automatic txn(input bit w, input bit ins, input bit [12:0] a,
                       input bit [12:0] d, input int dly, input bit poke);
        bit [13:0] key;
        bit [12:0] exp_rd;
        key    = {ins, a};
        exp_rd = w ? 13'd0 : ref_mem[key];
        if (w) ref_mem[key] = d;
        check("idle_ready", req_ready, 1'b1);
        req_valid = 1'b1;
        req_write = w;
        req_instr = ins;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1;
        if (poke) begin
            req_addr  = ~a;
            req_wdata = ~d;
            req_write = ~w;
            req_instr = ~ins;
        end else begin
            req_valid = 1'b0;
        end
        for (int k = 1; k <= dly; k++) begin
            @(negedge clk);
            check("wait_read", mem_read, !w);
            check("wait_write", mem_write, w);
            check("wait_addr", mem_address, a);
            check("wait_din", mem_dataIn, d);
            check("wait_instr", mem_instruction, ins);
            check("wait_ready", req_ready, 1'b0);
            check("wait_rsp", rsp_valid, 1'b0);
            if (k == dly) begin
                mem_done = 1'b1;
                if (mem_write)
                    mem_arr[{mem_instruction, mem_address}] = mem_dataIn;
                mem_dataOut = mem_write ? 13'($urandom)
                                        : mem_arr[{mem_instruction, mem_address}];
            end
        end
        @(posedge clk);
        #1;
        mem_done    = 1'b0;
        mem_dataOut = 13'($urandom);
        req_valid   = 1'b0;
        @(negedge clk);
        check("rsp_valid", rsp_valid, 1'b1);
        check("rsp_error", rsp_error, 1'b0);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_read_low", mem_read, 1'b0);
        check("rsp_write_low", mem_write, 1'b0);
        check("rsp_ready", req_ready, 1'b0);
        check("rsp_addr_kept", mem_address, a);
        check("rsp_instr_kept", mem_instruction, ins);
        @(negedge clk);
        check("post_valid", rsp_valid, 1'b0);
        check("post_ready", req_ready, 1'b1);
        check("post_addr_kept", mem_address, a);
        check("post_din_kept", mem_dataIn, d);
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_instr   = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        mem_dataOut = '0;
        mem_done    = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_error", rsp_error, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 13'd0);
        check("rst_addr", mem_address, 13'd0);
        check("rst_din", mem_dataIn, 13'd0);
        check("rst_write", mem_write, 1'b0);
        check("rst_read", mem_read, 1'b0);
        check("rst_instr", mem_instruction, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Done while idle must not produce a response.
        mem_done = 1'b1;
        @(negedge clk);
        check("idle_done_rsp", rsp_valid, 1'b0);
        check("idle_done_ready", req_ready, 1'b1);
        mem_done = 1'b0;

        // Plain read with fast memory.
        mem_arr[0] = 13'h10F0;
        ref_mem[0] = 13'h10F0;
        txn(1'b0, 1'b0, 13'd0, 13'd0, 1, 1'b0);

        // Store then load at address 5.
        txn(1'b1, 1'b0, 13'd5, 13'h0F0F, 1, 1'b0);
        txn(1'b0, 1'b0, 13'd5, 13'h0000, 2, 1'b0);

        // Slow fetch with a second request held during WAIT.
        mem_arr[{1'b1, 13'h0042}] = 13'h1ABC;
        ref_mem[{1'b1, 13'h0042}] = 13'h1ABC;
        txn(1'b0, 1'b1, 13'h0042, 13'h0123, 6, 1'b1);

        // Done exactly on the timeout edge counts as success.
        txn(1'b0, 1'b0, 13'd5, 13'h0000, TMO, 1'b0);

        // Randomized traffic over a small address window.
        for (int n = 0; n < 24; n++) begin
            txn(1'($urandom), 1'($urandom), 13'($urandom_range(0, 7)),
                13'($urandom), $urandom_range(1, TMO), 1'($urandom));
        end

`ifdef MEM_ACCESS_TIMEOUT_EN
        // No Done: abort after TMO WAIT cycles, late Done ignored.
        check("tmo_ready", req_ready, 1'b1);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_instr = 1'b0;
        req_addr  = 13'h00AB;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clk);
            check("tmo_wait_read", mem_read, 1'b1);
            check("tmo_wait_rsp", rsp_valid, 1'b0);
        end
        @(negedge clk);
        check("tmo_rsp_valid", rsp_valid, 1'b1);
        check("tmo_rsp_error", rsp_error, 1'b1);
        check("tmo_rsp_rdata", rsp_rdata, 13'd0);
        check("tmo_read_low", mem_read, 1'b0);
        mem_done    = 1'b1;
        mem_dataOut = 13'h1555;
        @(negedge clk);
        check("tmo_late_valid", rsp_valid, 1'b0);
        check("tmo_late_ready", req_ready, 1'b1);
        @(negedge clk);
        check("tmo_late_valid2", rsp_valid, 1'b0);
        check("tmo_late_read", mem_read, 1'b0);
        mem_done = 1'b0;
`endif

        // Reset two cycles into a read.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_instr = 1'b0;
        req_addr  = 13'h0123;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_read", mem_read, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_read", mem_read, 1'b0);
        check("arst_ready", req_ready, 1'b1);
        check("arst_rsp", rsp_valid, 1'b0);
        check("arst_addr", mem_address, 13'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("arst_no_rsp", rsp_valid, 1'b0);
            check("arst_idle_ready", req_ready, 1'b1);
        end
        txn(1'b0, 1'b0, 13'd5, 13'h0000, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
